// File: rtl/alu_ctrl_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decoder
//  Description : RV32I ALU control decoder. Maps ALUOp/funct3/funct7[5]/op[5]
//                to a 3-bit ALU operation, registered at the ID/EX boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [6:0] op,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    localparam logic [2:0] c_f3_add = 3'b000;
    localparam logic [2:0] c_f3_slt = 3'b010;
    localparam logic [2:0] c_f3_or  = 3'b110;
    localparam logic [2:0] c_f3_and = 3'b111;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    logic [2:0] w_alu_ctrl;
    logic       w_illegal;
    logic       w_is_sub;

    // Only R-type SUB sets funct7[5] meaningfully; for ADDI it is an immediate bit.
    assign w_is_sub = op[5] & funct7[5];

    // Remaining instruction bits are architecturally irrelevant here.
    logic w_unused_bits;
    assign w_unused_bits = ^{funct7[6], funct7[4:0], op[6], op[4:0]};

    always_comb begin
        w_alu_ctrl = c_alu_add;
        w_illegal  = 1'b0;
        case (ALUOp)
            c_aluop_add: w_alu_ctrl = c_alu_add;
            c_aluop_sub: w_alu_ctrl = c_alu_sub;
            c_aluop_funct: begin
                case (funct3)
                    c_f3_add: w_alu_ctrl = w_is_sub ? c_alu_sub : c_alu_add;
                    c_f3_slt: w_alu_ctrl = c_alu_slt;
                    c_f3_or:  w_alu_ctrl = c_alu_or;
                    c_f3_and: w_alu_ctrl = c_alu_and;
                    default: begin
                        w_alu_ctrl = c_alu_add;
                        w_illegal  = 1'b1;
                    end
                endcase
            end
            default: begin
                w_alu_ctrl = c_alu_add;
                w_illegal  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUControl <= c_alu_add;
            illegal    <= 1'b0;
        end else begin
            ALUControl <= w_alu_ctrl;
            illegal    <= w_illegal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_decoder
//  Description : Directed self-checking bench for alu_ctrl_decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] ALUOp = 2'b00;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct7 = 7'b0000000;
    logic [6:0] op = 7'b0000000;
    logic [2:0] ALUControl;
    logic       illegal;

    int checks = 0;
    int errors = 0;
    logic [2:0] prev_ctrl = 3'b000;
    logic       prev_ill  = 1'b0;

    alu_ctrl_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .funct7     (funct7),
        .op         (op),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive at negedge, confirm output still holds the previous result, then
    // confirm the new result one rising edge later.
    task automatic step(input string tag, input logic [1:0] a, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [6:0] o,
                        input logic [2:0] exp_ctrl, input logic exp_ill);
        @(negedge clk);
        ALUOp = a; funct3 = f3; funct7 = f7; op = o;
        #1;
        chk({tag, "_hold_ctrl"}, ALUControl, prev_ctrl);
        chk({tag, "_hold_ill"}, {2'b00, illegal}, {2'b00, prev_ill});
        @(posedge clk);
        #1;
        chk({tag, "_ctrl"}, ALUControl, exp_ctrl);
        chk({tag, "_ill"}, {2'b00, illegal}, {2'b00, exp_ill});
        prev_ctrl = exp_ctrl;
        prev_ill  = exp_ill;
    endtask

    logic [1:0] v_a  [8];
    logic [2:0] v_f3 [8];
    logic [6:0] v_f7 [8];
    logic [6:0] v_op [8];
    logic [2:0] v_ec [8];
    logic       v_ei [8];

    initial begin
        // Reset asserted asynchronously while ALUOp=01 is presented
        ALUOp = 2'b01; funct3 = 3'b101;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_ctrl", ALUControl, 3'b000);
        chk("reset_async_ill", {2'b00, illegal}, 3'b000);
        @(posedge clk); #1;
        chk("reset_held_ctrl", ALUControl, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_ctrl", ALUControl, 3'b000);
        @(posedge clk); #1;
        chk("post_reset_ctrl", ALUControl, 3'b001);
        chk("post_reset_ill", {2'b00, illegal}, 3'b000);
        prev_ctrl = 3'b001; prev_ill = 1'b0;

        step("aluop00", 2'b00, 3'b111, 7'b0100000, 7'b0110011, 3'b000, 1'b0);
        step("aluop01", 2'b01, 3'b110, 7'b0100000, 7'b0110011, 3'b001, 1'b0);
        step("r_sub",   2'b10, 3'b000, 7'b0100000, 7'b0110011, 3'b001, 1'b0);
        step("addi_f7", 2'b10, 3'b000, 7'b0100000, 7'b0010011, 3'b000, 1'b0);
        step("r_add",   2'b10, 3'b000, 7'b0000000, 7'b0110011, 3'b000, 1'b0);
        step("bit0_ign",2'b10, 3'b000, 7'b0000001, 7'b0000001, 3'b000, 1'b0);
        step("slt",     2'b10, 3'b010, 7'b0000000, 7'b0110011, 3'b101, 1'b0);
        step("or",      2'b10, 3'b110, 7'b0000000, 7'b0110011, 3'b011, 1'b0);
        step("and",     2'b10, 3'b111, 7'b0000000, 7'b0010011, 3'b010, 1'b0);
        step("f3_100",  2'b10, 3'b100, 7'b0000000, 7'b0110011, 3'b000, 1'b1);
        step("aluop11", 2'b11, 3'b010, 7'b0000000, 7'b0110011, 3'b000, 1'b1);
        step("f3_001",  2'b10, 3'b001, 7'b0100000, 7'b0110011, 3'b000, 1'b1);
        step("f3_101",  2'b10, 3'b101, 7'b0000000, 7'b0010011, 3'b000, 1'b1);
        step("sub_hi",  2'b10, 3'b000, 7'b1111111, 7'b1111111, 3'b001, 1'b0);
        step("nosub_hi",2'b10, 3'b000, 7'b1011111, 7'b1011111, 3'b000, 1'b0);

        // Back-to-back stream: output must trail input by exactly one edge
        v_a[0]=2'b10; v_f3[0]=3'b111; v_f7[0]=7'h00; v_op[0]=7'h33; v_ec[0]=3'b010; v_ei[0]=1'b0;
        v_a[1]=2'b10; v_f3[1]=3'b110; v_f7[1]=7'h00; v_op[1]=7'h33; v_ec[1]=3'b011; v_ei[1]=1'b0;
        v_a[2]=2'b01; v_f3[2]=3'b000; v_f7[2]=7'h00; v_op[2]=7'h63; v_ec[2]=3'b001; v_ei[2]=1'b0;
        v_a[3]=2'b11; v_f3[3]=3'b000; v_f7[3]=7'h00; v_op[3]=7'h33; v_ec[3]=3'b000; v_ei[3]=1'b1;
        v_a[4]=2'b10; v_f3[4]=3'b010; v_f7[4]=7'h20; v_op[4]=7'h13; v_ec[4]=3'b101; v_ei[4]=1'b0;
        v_a[5]=2'b10; v_f3[5]=3'b000; v_f7[5]=7'h20; v_op[5]=7'h33; v_ec[5]=3'b001; v_ei[5]=1'b0;
        v_a[6]=2'b00; v_f3[6]=3'b010; v_f7[6]=7'h00; v_op[6]=7'h03; v_ec[6]=3'b000; v_ei[6]=1'b0;
        v_a[7]=2'b10; v_f3[7]=3'b011; v_f7[7]=7'h00; v_op[7]=7'h33; v_ec[7]=3'b000; v_ei[7]=1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ALUOp = v_a[i]; funct3 = v_f3[i]; funct7 = v_f7[i]; op = v_op[i];
            @(posedge clk); #1;
            chk($sformatf("stream%0d_ctrl", i), ALUControl, v_ec[i]);
            chk($sformatf("stream%0d_ill", i), {2'b00, illegal}, {2'b00, v_ei[i]});
        end
        prev_ctrl = v_ec[7]; prev_ill = v_ei[7];

        // Mid-stream reset discards the pending decode
        @(negedge clk);
        ALUOp = 2'b10; funct3 = 3'b110; funct7 = 7'h00; op = 7'h33;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", ALUControl, 3'b000);
        chk("midrst_ill", {2'b00, illegal}, 3'b000);
        @(posedge clk); #1;
        chk("midrst_held", ALUControl, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_after", ALUControl, 3'b011);
        chk("midrst_after_ill", {2'b00, illegal}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
